// File: rtl/exe_muldiv_ctrl_pkg.sv
// Shared encodings for the execute-stage iterative multiply/divide sequencer.
package exe_muldiv_ctrl_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration on the packed {hi,lo} / {rem,quot} accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                mode_div,
  input  logic [2*XLEN-1:0]   acc_in,
  input  logic [XLEN-1:0]     opnd,
  output logic [2*XLEN-1:0]   acc_out
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] trial;
  logic            fits;

  always_comb begin
    hi      = acc_in[2*XLEN-1:XLEN];
    lo      = acc_in[XLEN-1:0];
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh  = {hi, lo[XLEN-1]};
    fits    = rem_sh >= {1'b0, opnd};
    // Whenever fits is set the difference is below the divisor, so XLEN bits suffice.
    trial   = rem_sh[XLEN-1:0] - opnd;
    acc_out = {sum, lo[XLEN-1:1]};
    if (mode_div) begin
      if (fits) acc_out = {trial, lo[XLEN-2:0], 1'b1};
      else      acc_out = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer for the EXE stage; stalls the front end for the
// fixed-length loop and presents a registered result for one cycle.
//
// state | meaning
// IDLE  | waiting for a mul/div op in EXE
// CALC  | one multiply/divide iteration per cycle, ITER cycles
// DONE  | result/rdest valid, done pulse, pipeline released
module exe_muldiv_ctrl
  import exe_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = exe_muldiv_ctrl_pkg::ITER
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] eqa,
  input  logic [XLEN-1:0] eqb,
  input  logic [4:0]      edestReg,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdest,
  output logic            div_zero
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              bzero_q, bzero_d;
  logic [4:0]        dest_q, dest_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rdest_q, rdest_d;
  logic [2*XLEN-1:0] step_out;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_div (op_q[1]),
    .acc_in   (acc_q),
    .opnd     (opnd_q),
    .acc_out  (step_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    bzero_d  = bzero_q;
    dest_d   = dest_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    result_d = result_q;
    rdest_d  = rdest_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          // Multiply seeds lo with the multiplier; divide seeds quot with the dividend.
          acc_d   = op[1] ? {{XLEN{1'b0}}, eqa} : {{XLEN{1'b0}}, eqb};
          opnd_d  = op[1] ? eqb : eqa;
          bzero_d = (eqb == '0);
          dest_d  = edestReg;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = step_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          dz_d    = op_q[1] & bzero_q;
          rdest_d = dest_q;
          unique case (op_q)
            OP_MUL:   result_d = step_out[XLEN-1:0];
            OP_MULHU: result_d = step_out[2*XLEN-1:XLEN];
            OP_DIVU:  result_d = step_out[XLEN-1:0];
            OP_REMU:  result_d = step_out[2*XLEN-1:XLEN];
            default:  result_d = result_q;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      result_d = result_q;
      rdest_d  = rdest_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      bzero_q  <= 1'b0;
      dest_q   <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      rdest_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      bzero_q  <= bzero_d;
      dest_q   <= dest_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      rdest_q  <= rdest_d;
    end
  end

  // stall must cover the acceptance cycle itself, so it cannot wait for the state register.
  assign stall    = rst_n & (((state_q == IDLE) & start & ~flush) | (state_q == CALC));
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign result   = result_q;
  assign rdest    = rdest_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Directed bench for exe_muldiv_ctrl: latency, results, divide-by-zero, flush and async reset.
module tb_exe_muldiv_ctrl;
  import exe_muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] eqa = '0;
  logic [31:0] eqb = '0;
  logic [4:0]  edestReg = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done, div_zero;
  logic [31:0] result;
  logic [4:0]  rdest;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  exe_muldiv_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .eqa      (eqa),
    .eqb      (eqb),
    .edestReg (edestReg),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rdest    (rdest),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, hold start until DONE, and check latency, outputs and the return to IDLE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input logic exp_dz);
    int stalls = 0;
    @(negedge clk);
    start = 1'b1; op = o; eqa = a; eqb = b; edestReg = rd;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) break;
      if (stall) stalls++;
      @(negedge clk);
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_stall_cycles"}, stalls, 32'd33);
    chk({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_rdest"}, {27'd0, rdest}, {27'd0, rd});
    chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
    chk({tag, "_dz_after"}, {31'd0, div_zero}, 32'd0);
    chk({tag, "_result_hold"}, result, exp);
    last_res = exp;
    last_rd  = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b1;
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rdest", {27'd0, rdest}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7x6",    OP_MUL,   32'd7,          32'd6,          5'd5,  32'd42,         1'b0);
    run_op("mul_ff",     OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0001,  1'b0);
    run_op("mulhu_ff",   OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  1'b0);
    run_op("mulhu_big",  OP_MULHU, 32'h8000_0000,  32'h0000_0006,  5'd4,  32'h0000_0003,  1'b0);
    run_op("divu_100_7", OP_DIVU,  32'd100,        32'd7,          5'd3,  32'd14,         1'b0);
    run_op("remu_100_7", OP_REMU,  32'd100,        32'd7,          5'd6,  32'd2,          1'b0);
    run_op("divu_msb_1", OP_DIVU,  32'h8000_0000,  32'd1,          5'd8,  32'h8000_0000,  1'b0);
    run_op("divu_ff_16", OP_DIVU,  32'hFFFF_FFFF,  32'd16,         5'd10, 32'h0FFF_FFFF,  1'b0);
    run_op("remu_ff_16", OP_REMU,  32'hFFFF_FFFF,  32'd16,         5'd11, 32'h0000_000F,  1'b0);
    run_op("divu_3_10",  OP_DIVU,  32'd3,          32'd10,         5'd12, 32'd0,          1'b0);
    run_op("remu_3_10",  OP_REMU,  32'd3,          32'd10,         5'd13, 32'd3,          1'b0);
    run_op("divu_5_0",   OP_DIVU,  32'd5,          32'd0,          5'd14, 32'hFFFF_FFFF,  1'b1);
    run_op("remu_5_0",   OP_REMU,  32'd5,          32'd0,          5'd15, 32'd5,          1'b1);
    run_op("mul_x_0",    OP_MUL,   32'd9,          32'd0,          5'd16, 32'd0,          1'b0);

    // flush beats start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MUL; eqa = 32'd2; eqb = 32'd2; edestReg = 5'd20;
    #1;
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // flush mid-CALC at E0+10
    @(negedge clk);
    start = 1'b1; op = OP_MUL; eqa = 32'd3; eqb = 32'd4; edestReg = 5'd9;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      #1;
      chk("flush_no_early_done", {31'd0, done}, 32'd0);
    end
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result_hold", result, last_res);
    chk("flush_rdest_hold", {27'd0, rdest}, {27'd0, last_rd});
    run_op("after_flush", OP_MUL, 32'd3, 32'd4, 5'd9, 32'd12, 1'b0);

    // async reset mid-CALC with start held
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; eqa = 32'd100; eqb = 32'd7; edestReg = 5'd7;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_rdest", {27'd0, rdest}, 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_stall_held", {31'd0, stall}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    run_op("after_rst", OP_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_ctrl.md
# exe_muldiv_ctrl

Iterative multiply/divide sequencer attached to the execute stage of the pipelined CPU. It accepts an unsigned MUL, MULHU, DIVU or REMU operation from the instruction in EXE and stalls the front of the pipeline while it runs a fixed 32-iteration shift-add or restoring-divide loop. It then presents a 32-bit result and destination register for one cycle, so the EXE/MEM pipeline register captures it in place of the ALU result. Single-cycle ALU operations bypass this block entirely.

## Interface
Parameters:
- XLEN, 32, operand/result width
- ITER, 32, iterations per operation (equal to XLEN)

Ports:
- clk  in  1  pipeline clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  EXE instruction is a mul/div op; held high while that instruction sits in EXE
- op  in  2  00 MUL (low 32), 01 MULHU (high 32), 10 DIVU, 11 REMU
- eqa  in  XLEN  operand A (multiplicand / dividend)
- eqb  in  XLEN  operand B (multiplier / divisor)
- edestReg  in  5  destination register of the EXE instruction
- flush  in  1  kill the in-flight operation (branch/exception squash)
- stall  out  1  hold PC, IF/ID and ID/EXE registers this cycle
- busy  out  1  sequencer not IDLE
- done  out  1  result valid this cycle (one-cycle pulse)
- result  out  XLEN  operation result
- rdest  out  5  destination register latched at start
- div_zero  out  1  the completed operation had divisor 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if start and !flush → latch op, eqa, eqb and edestReg; clear the accumulator; cnt=0; go to CALC. start is sampled only in IDLE.
- CALC: one iteration per cycle; cnt increments; after iteration ITER-1 (cnt==31) → DONE.
  - Multiply: 64-bit {hi,lo} with lo=multiplier. If lo[0], hi+=multiplicand (33-bit carry kept). Then shift the 65-bit {carry,hi,lo} right by 1.
  - Divide (restoring): shift {rem,quot} left by 1. Trial = rem − divisor (33-bit). If non-negative, rem=trial and quot[0]=1.
- DONE: result = lo (MUL), hi (MULHU), quot (DIVU) or rem (REMU); done=1; → IDLE unconditionally. A start high in DONE belongs to the finishing instruction and is ignored.
- Divide by zero: latency stays fixed. DIVU gives 0xFFFFFFFF; REMU gives the dividend; div_zero=1 in DONE.
- flush in any state: next state IDLE, no done pulse, result/rdest unchanged. flush has priority over start.
- stall = (IDLE & start & !flush) | CALC. Stall is 0 in DONE so the pipeline advances and EXE/MEM captures result/rdest.
- busy = state != IDLE.

## Timing
- Start accepted at edge E0 (start high in IDLE). CALC occupies cycles E0+1 … E0+32; DONE is in cycle E0+33; IDLE again at E0+34.
- stall is high for 33 consecutive cycles (acceptance cycle plus 32 CALC cycles) and low in DONE.
- done, result, div_zero and rdest are registered and valid only in the DONE cycle. result and rdest hold their value afterwards; done and div_zero clear.
- Back-to-back: the next mul/div in EXE is sampled in the first IDLE cycle after DONE. Minimum spacing is 34 cycles.
- Reset (rst_n low, any time, including mid-CALC): state=IDLE, cnt=0, done=0, busy=0, div_zero=0, result=0, rdest=0. stall is forced to 0 while rst_n is low. Operation resumes on the first edge after release.

## Structure
- The shared CPU package holds: op encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU), the state enum (IDLE/CALC/DONE), and ITER.
- One sub-module, muldiv_step: combinational single iteration. Inputs are mode, {hi,lo} or {rem,quot}, and operand B; output is the next-iteration value. exe_muldiv_ctrl owns the FSM, counter, operand latches and output registers.

## Test plan
- MUL 7×6, edestReg=5 → stall high 33 cycles; at E0+33: done=1, result=42, rdest=5. done is low before and after.
- 0xFFFFFFFF×0xFFFFFFFF: MUL → 0x00000001; MULHU → 0xFFFFFFFE.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0x80000000/1 → 0x80000000.
- DIVU 5/0 → 0xFFFFFFFF with div_zero=1; REMU 5/0 → 5 with div_zero=1; full 33-cycle latency in both cases.
- flush at cycle E0+10 → IDLE at E0+11, stall=0, no done. A new start at E0+11 is accepted and completes at E0+44.
- rst_n low at E0+15 with start held high → outputs zero immediately and stall=0 during reset. After release, start in IDLE begins a fresh operation with correct result.
